// File: rtl/ring_period_meter.sv
// Ring oscillator period meter: synchronises ring_clk into the reference domain and
// publishes the period averaged over 2^LOG2_N ring periods, plus overflow and stall flags.
module ring_period_meter #(
   parameter int WIDTH   = 8,
   parameter int LOG2_N  = 2,
   parameter int TIMEOUT = 1023,
   parameter int TO_W    = 10
) (
   input  logic             clk_frequency,
   input  logic             rst_frequency,
   input  logic             init,
   input  logic             ring_clk,
   output logic [WIDTH-1:0] period_out,
   output logic             period_valid,
   output logic             overflow,
   output logic             stall,
   output logic             busy
);

   localparam int ACC_W     = WIDTH + LOG2_N;
   localparam int N_PERIODS = 1 << LOG2_N;
   localparam int EDGE_W    = (LOG2_N > 0) ? LOG2_N : 1;
   localparam int PMAX      = (1 << WIDTH) - 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARM     = 2'd1,
      MEASURE = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [2:0]          sync_q;
   logic [ACC_W-1:0]    acc_q, acc_d;
   logic [EDGE_W-1:0]   edge_q, edge_d;
   logic                sat_q, sat_d;
   logic [TO_W-1:0]     to_q, to_d;
   logic [WIDTH-1:0]    period_q, period_d;
   logic                valid_q, valid_d;
   logic                ovf_q, ovf_d;
   logic                stall_q, stall_d;
   logic                busy_q, busy_d;

   logic                rise;
   logic                acc_full;
   logic [ACC_W-1:0]    total;
   logic                sat_now;
   logic [ACC_W-1:0]    avg;
   logic                avg_big;
   logic                to_hit;

   // Saturating increment of the window accumulator and the averaged result it would publish.
   always_comb begin
      rise     = sync_q[1] & ~sync_q[2];
      acc_full = (acc_q == {ACC_W{1'b1}});
      total    = acc_full ? acc_q : (acc_q + ACC_W'(1));
      sat_now  = sat_q | acc_full;
      avg      = total >> LOG2_N;
      avg_big  = (avg > ACC_W'(PMAX));
      to_hit   = (to_q == TO_W'(TIMEOUT - 1));
   end

   // Next-state and output logic; priority is init-drop, then rise, then timeout.
   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      edge_d   = edge_q;
      sat_d    = sat_q;
      to_d     = to_q;
      period_d = period_q;
      valid_d  = 1'b0;
      ovf_d    = ovf_q;
      stall_d  = stall_q;
      case (state_q)
         IDLE: begin
            to_d = {TO_W{1'b0}};
            if (init) begin
               state_d = ARM;
            end else begin
               state_d = IDLE;
            end
         end
         ARM: begin
            if (!init) begin
               state_d = IDLE;
               stall_d = 1'b0;
            end else if (rise) begin
               acc_d   = {ACC_W{1'b0}};
               edge_d  = {EDGE_W{1'b0}};
               sat_d   = 1'b0;
               to_d    = {TO_W{1'b0}};
               state_d = MEASURE;
            end else if (to_hit) begin
               stall_d = 1'b1;
               to_d    = {TO_W{1'b0}};
            end else begin
               to_d = to_q + TO_W'(1);
            end
         end
         MEASURE: begin
            if (!init) begin
               state_d = IDLE;
               stall_d = 1'b0;
            end else if (rise) begin
               to_d = {TO_W{1'b0}};
               // The closing edge of one window is the opening edge of the next.
               if (edge_q == EDGE_W'(N_PERIODS - 1)) begin
                  period_d = avg_big ? {WIDTH{1'b1}} : avg[WIDTH-1:0];
                  ovf_d    = sat_now | avg_big;
                  valid_d  = 1'b1;
                  stall_d  = 1'b0;
                  acc_d    = {ACC_W{1'b0}};
                  edge_d   = {EDGE_W{1'b0}};
                  sat_d    = 1'b0;
               end else begin
                  acc_d  = total;
                  edge_d = edge_q + EDGE_W'(1);
                  sat_d  = sat_now;
               end
            end else if (to_hit) begin
               stall_d = 1'b1;
               to_d    = {TO_W{1'b0}};
               state_d = ARM;
            end else begin
               to_d  = to_q + TO_W'(1);
               acc_d = total;
               sat_d = sat_now;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   // State, synchroniser and registered outputs.
   always_ff @(posedge clk_frequency) begin
      if (rst_frequency) begin
         state_q  <= IDLE;
         sync_q   <= 3'b000;
         acc_q    <= {ACC_W{1'b0}};
         edge_q   <= {EDGE_W{1'b0}};
         sat_q    <= 1'b0;
         to_q     <= {TO_W{1'b0}};
         period_q <= {WIDTH{1'b0}};
         valid_q  <= 1'b0;
         ovf_q    <= 1'b0;
         stall_q  <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         sync_q   <= {sync_q[1:0], ring_clk};
         acc_q    <= acc_d;
         edge_q   <= edge_d;
         sat_q    <= sat_d;
         to_q     <= to_d;
         period_q <= period_d;
         valid_q  <= valid_d;
         ovf_q    <= ovf_d;
         stall_q  <= stall_d;
         busy_q   <= busy_d;
      end
   end

   assign period_out   = period_q;
   assign period_valid = valid_q;
   assign overflow     = ovf_q;
   assign stall        = stall_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_ring_period_meter.sv
// Bench for ring_period_meter: directed scenarios plus randomized ring periods,
// init drops and resets, checked every cycle against an event-level reference model.
module tb_ring_period_meter;

   localparam int WIDTH   = 8;
   localparam int LOG2_N  = 2;
   localparam int TIMEOUT = 1023;
   localparam int TO_W    = 10;
   localparam int NP      = 1 << LOG2_N;
   localparam int ACC_MAX = (1 << (WIDTH + LOG2_N)) - 1;
   localparam int PMAX    = (1 << WIDTH) - 1;

   logic             clk_frequency = 1'b0;
   logic             rst_frequency = 1'b1;
   logic             init          = 1'b0;
   logic             ring_clk      = 1'b0;
   logic [WIDTH-1:0] period_out;
   logic             period_valid;
   logic             overflow;
   logic             stall;
   logic             busy;

   ring_period_meter #(.WIDTH(WIDTH), .LOG2_N(LOG2_N), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
      .clk_frequency(clk_frequency),
      .rst_frequency(rst_frequency),
      .init(init),
      .ring_clk(ring_clk),
      .period_out(period_out),
      .period_valid(period_valid),
      .overflow(overflow),
      .stall(stall),
      .busy(busy)
   );

   always #10 clk_frequency = ~clk_frequency;

   int checks = 0;
   int errors = 0;

   // ring generator: periods in reference cycles, 0 means held low
   int base_per = 0;
   int cur_per  = 0;
   int ph       = 0;
   int per_q[$];

   // reference model: 0 idle, 1 waiting for first edge, 2 measuring
   int m_mode = 0, m_win = 0, m_edges = 0, m_quiet = 0, m_cyc = 0, m_last_rise = 0;
   bit smp[$] = '{1'b0, 1'b0, 1'b0};
   int e_period = 0;
   bit e_valid = 1'b0, e_ovf = 1'b0, e_stall = 1'b0, e_busy = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0d want %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic drive_ring();
      if (cur_per == 0 && base_per != 0) begin
         cur_per = base_per;
         ph      = 0;
      end
      if (cur_per == 0) begin
         ring_clk = 1'b0;
      end else begin
         ring_clk = (ph < cur_per / 2);
         ph++;
         if (ph >= cur_per) begin
            ph = 0;
            if (per_q.size() > 0) cur_per = per_q.pop_front();
            else cur_per = base_per;
         end
      end
   endtask

   task automatic publish();
      int tot, avg;
      tot      = (m_win > ACC_MAX) ? ACC_MAX : m_win;
      avg      = tot >> LOG2_N;
      e_period = (avg > PMAX) ? PMAX : avg;
      e_ovf    = (m_win > ACC_MAX) || (avg > PMAX);
      e_valid  = 1'b1;
      e_stall  = 1'b0;
      m_win    = 0;
      m_edges  = 0;
   endtask

   task automatic model_step(input bit r, input bit in, input bit rg);
      bit rise;
      m_cyc++;
      e_valid = 1'b0;
      if (r) begin
         m_mode = 0; m_win = 0; m_edges = 0; m_quiet = 0; m_last_rise = m_cyc;
         e_period = 0; e_ovf = 1'b0; e_stall = 1'b0;
         smp = '{1'b0, 1'b0, 1'b0};
      end else begin
         // raw level seen two and three edges ago: a rise is 0 then 1 after sync delay
         rise = smp[1] & ~smp[2];
         smp.push_front(rg);
         void'(smp.pop_back());
         if (rise) m_last_rise = m_cyc;
         if (m_mode == 0) begin
            if (in) begin m_mode = 1; m_quiet = 0; end
         end else if (!in) begin
            m_mode  = 0;
            e_stall = 1'b0;
         end else if (rise) begin
            m_quiet = 0;
            if (m_mode == 1) begin
               m_mode = 2; m_win = 0; m_edges = 0;
            end else begin
               m_win++;
               m_edges++;
               if (m_edges == NP) publish();
            end
         end else begin
            if (m_mode == 2) m_win++;
            m_quiet++;
            if (m_quiet == TIMEOUT) begin
               e_stall = 1'b1; m_mode = 1; m_quiet = 0;
            end
         end
      end
      e_busy = (m_mode != 0);
   endtask

   task automatic tick();
      bit r, i, g;
      drive_ring();
      r = rst_frequency; i = init; g = ring_clk;
      @(posedge clk_frequency);
      #1;
      model_step(r, i, g);
      chk("period_out", period_out, e_period);
      chk("period_valid", period_valid, e_valid);
      chk("overflow", overflow, e_ovf);
      chk("stall", stall, e_stall);
      chk("busy", busy, e_busy);
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic wait_valid(input int budget, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!e_valid && n < budget);
      if (!e_valid) chk("wait_valid_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      int n;
      int sel;
      // reset state
      ticks(3);
      chk("reset_period", period_out, 0);
      chk("reset_busy", busy, 0);
      chk("reset_stall", stall, 0);

      // steady 10-cycle ring
      rst_frequency = 1'b0; init = 1'b1; base_per = 10;
      wait_valid(300, n);
      chk("p10_first", period_out, 10);
      chk("p10_ovf", overflow, 0);
      chk("p10_busy", busy, 1);
      wait_valid(200, n);
      chk("p10_interval", n, 40);
      chk("p10_second", period_out, 10);

      // 10,11,9,10 averages to 10; 10,9,9,9 truncates 37/4 to 9
      per_q.push_back(11); per_q.push_back(9); per_q.push_back(10);
      wait_valid(200, n);
      chk("mix_40", period_out, 10);
      per_q.push_back(9); per_q.push_back(9); per_q.push_back(9);
      wait_valid(200, n);
      chk("trunc_37", period_out, 9);

      // slow ring saturates, then recovers
      base_per = 300;
      wait_valid(2000, n);
      wait_valid(2000, n);
      chk("slow_period", period_out, 255);
      chk("slow_ovf", overflow, 1);
      base_per = 10;
      wait_valid(2000, n);
      wait_valid(200, n);
      chk("recover_period", period_out, 10);
      chk("recover_ovf", overflow, 0);

      // oscillator stops: stall after TIMEOUT quiet cycles, then clears on next strobe
      base_per = 0;
      n = 0;
      while (stall !== 1'b1 && n < 1300) begin tick(); n++; end
      chk("stall_set", stall, 1);
      chk("stall_gap", m_cyc - m_last_rise, TIMEOUT);
      chk("stall_busy", busy, 1);
      ticks(50);
      base_per = 10;
      wait_valid(300, n);
      chk("stall_cleared", stall, 0);
      chk("stall_recover_period", period_out, 10);

      // init dropped two periods into a window
      ticks(20);
      init = 1'b0;
      tick();
      chk("drop_busy", busy, 0);
      ticks(15);
      chk("drop_hold", period_out, 10);
      init = 1'b1;
      wait_valid(300, n);
      chk("drop_fresh_window", n >= 40, 1);

      // one-cycle reset mid-window
      ticks(15);
      rst_frequency = 1'b1;
      tick();
      rst_frequency = 1'b0;
      chk("midrst_period", period_out, 0);
      chk("midrst_busy", busy, 0);
      wait_valid(300, n);
      chk("midrst_fresh_window", n >= 40, 1);

      // randomized segments
      for (int s = 0; s < 40; s++) begin
         sel = $urandom_range(0, 15);
         if (sel == 0) begin
            rst_frequency = 1'b1; tick(); rst_frequency = 1'b0;
         end else if (sel == 1) begin
            init = 1'b0; ticks($urandom_range(1, 30)); init = 1'b1;
         end else if (sel == 2) begin
            base_per = 0; ticks($urandom_range(1050, 1200));
         end else if (sel < 13) begin
            base_per = $urandom_range(4, 16);
         end else begin
            base_per = $urandom_range(250, 300);
         end
         ticks($urandom_range(50, 400));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
